// File: rtl/fetch_unit.sv
// Instruction fetch unit: 16-word instruction memory, PC sequencing with branch/halt, valid/ready issue.
// Optional jump support is compiled in with `define FETCH_JUMP_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        imem_we,
    input  logic [3:0]  imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic        valid,
    output logic        halted
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [5:0]  OP_HALT = 6'b111111;
`ifdef FETCH_JUMP_EN
    localparam logic [5:0]  OP_JUMP = 6'b000010;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   pc_d, instr_d, pc_plus4, br_off;
    logic              valid_d, halted_d;

    // Instruction memory: no reset, writes land at the edge so a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    assign pc_plus4 = PC + XLEN'(4);
    assign br_off   = {{(XLEN-18){Instr[15]}}, Instr[15:0], 2'b00};
    assign Op       = Instr[31:26];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            PC     <= '0;
            Instr  <= '0;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_d;
            PC     <= pc_d;
            Instr  <= instr_d;
            valid  <= valid_d;
            halted <= halted_d;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = PC;
        instr_d  = Instr;
        valid_d  = valid;
        halted_d = halted;
        case (state)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                instr_d = mem[PC[5:2]];
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (Op == OP_HALT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
`ifdef FETCH_JUMP_EN
                        if (Op == OP_JUMP) begin
                            pc_d = {pc_plus4[31:28], Instr[25:0], 2'b00};
                        end else if (Branch && Zero) begin
                            pc_d = pc_plus4 + br_off;
                        end else begin
                            pc_d = pc_plus4;
                        end
`else
                        if (Branch && Zero) begin
                            pc_d = pc_plus4 + br_off;
                        end else begin
                            pc_d = pc_plus4;
                        end
`endif
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetches are queued on stimulus and checked when valid rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, ready, Branch, Zero, imem_we;
    logic [3:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] PC, Instr;
    logic [5:0]  Op;
    logic        valid, halted;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tb_mem [16];
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .Branch(Branch), .Zero(Zero), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .PC(PC), .Instr(Instr), .Op(Op), .valid(valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data);
        imem_we = 1'b1; imem_waddr = idx; imem_wdata = data;
        tick();
        imem_we = 1'b0;
        tb_mem[idx] = data;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = tb_mem[pc[5:2]];
        sb.push_back(e);
    endtask

    // Wait (bounded) for valid, then compare against the oldest queued expectation.
    task automatic wait_valid(input string tag);
        exp_t e;
        int   n = 0;
        logic [31:0] op_exp;
        while (!valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            op_exp = 32'(e.instr[31:26]);
            chk({tag, "_pc"}, PC, e.pc);
            chk({tag, "_instr"}, Instr, e.instr);
            chk({tag, "_op"}, 32'(Op), op_exp);
        end
    endtask

    task automatic hs(input string tag, input logic br, input logic z);
        ready = 1'b1; Branch = br; Zero = z;
        tick();
        ready = 1'b0; Branch = 1'b0; Zero = 1'b0;
        chk({tag, "_bubble"}, 32'(valid), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ready = 1'b0; Branch = 1'b0; Zero = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'hx;
        #12;
        tick();
        chk("rst_pc", PC, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_op", 32'(Op), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        wr(4'd0, 32'h0000_0000);
        wr(4'd1, 32'h1000_0003);
        wr(4'd2, 32'hFC00_0000);
        wr(4'd5, 32'h1000_FFFA);
        chk("idle_valid", 32'(valid), 32'd0);

        // Start-to-valid latency of two edges.
        expect_fetch(32'h0);
        pulse_start();
        chk("fetch_no_valid", 32'(valid), 32'd0);
        tick();
        chk("latency2", 32'(valid), 32'd1);
        wait_valid("pc0");

        hs("hs0", 1'b0, 1'b0);
        expect_fetch(32'h4);
        wait_valid("pc4");

        // Stall: outputs hold; start/Branch/Zero ignored without handshake.
        start = 1'b1; Branch = 1'b1; Zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", PC, 32'h4);
            chk("stall_instr", Instr, 32'h1000_0003);
            chk("stall_valid", 32'(valid), 32'd1);
        end
        start = 1'b0; Branch = 1'b0; Zero = 1'b0;

        hs("beq_taken", 1'b1, 1'b1);
        expect_fetch(32'h14);
        wait_valid("pc14");

        // Negative offset: 0x14 + 4 - 24 = 0.
        hs("beq_back", 1'b1, 1'b1);
        expect_fetch(32'h0);
        wait_valid("pc0b");

        hs("hs0b", 1'b0, 1'b0);
        expect_fetch(32'h4);
        wait_valid("pc4b");

        hs("beq_not_taken", 1'b1, 1'b0);
        expect_fetch(32'h8);
        wait_valid("pc8");

        // Halt opcode with branch fields set: PC stays.
        hs("halt", 1'b1, 1'b1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", PC, 32'h8);
        start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_stay_valid", 32'(valid), 32'd0);
            chk("halt_stay_halted", 32'(halted), 32'd1);
        end
        start = 1'b0; ready = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_halted", 32'(halted), 32'd0);

        // Write during FETCH to the fetched index: old word is fetched.
        pulse_start();
        expect_fetch(32'h0);
        imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 32'h0800_0005;
        tick();
        imem_we = 1'b0;
        tb_mem[0] = 32'h0800_0005;
        wait_valid("rd_old");

        hs("hs_r", 1'b0, 1'b0);
        expect_fetch(32'h4);
        wait_valid("pc4c");

        // Async reset mid-ISSUE: outputs clear before the next edge.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", PC, 32'd0);
        chk("arst_instr", Instr, 32'd0);
        chk("arst_op", 32'(Op), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        tick();
        reset = 1'b0;

        // Memory retained across reset; jump opcode behaviour depends on build.
        expect_fetch(32'h0);
        pulse_start();
        wait_valid("jmp_fetch");
        hs("jmp_hs", 1'b0, 1'b0);
`ifdef FETCH_JUMP_EN
        expect_fetch(32'h14);
`else
        expect_fetch(32'h4);
`endif
        wait_valid("jmp_next");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
